// File: rtl/instr_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv (package)
// Description : RV32I opcode/funct3 encodings, immediate widths and the
//               shared signed-range helper used by the instruction encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package rv;

  // Base RV32I major opcodes
  typedef enum logic [6:0] {
    RV32_OP_LOAD   = 7'b0000011,
    RV32_OP_IMM    = 7'b0010011,
    RV32_OP_AUIPC  = 7'b0010111,
    RV32_OP_STORE  = 7'b0100011,
    RV32_OP_ARITH  = 7'b0110011,
    RV32_OP_LUI    = 7'b0110111,
    RV32_OP_BRANCH = 7'b1100011,
    RV32_OP_JALR   = 7'b1100111,
    RV32_OP_JAL    = 7'b1101111
  } RV32_INSTRUCTION_OPCODE;

  // ALU funct3 encodings (ADD/SUB and SRL/SRA share a code, split by bit 30)
  typedef enum logic [2:0] {
    RV32_ALU_ADD  = 3'b000,
    RV32_ALU_SLL  = 3'b001,
    RV32_ALU_SLT  = 3'b010,
    RV32_ALU_SLTU = 3'b011,
    RV32_ALU_XOR  = 3'b100,
    RV32_ALU_SR   = 3'b101,
    RV32_ALU_OR   = 3'b110,
    RV32_ALU_AND  = 3'b111
  } RV32_ALU_OPCODE;

  localparam int FUNCT7_ALT_BIT = 30;
  localparam int IMM_I_W        = 12;
  localparam int IMM_B_W        = 13;
  localparam int IMM_J_W        = 21;

  // True when value is representable as a WIDTH-bit two's complement number,
  // i.e. every bit from the sign position upward is identical.
  function automatic logic fits_signed(input logic [31:0] value, input int width);
    logic [31:0] upper;
    upper = 32'($signed(value) >>> (width - 1));
    return (upper == '0) || (upper == '1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_encoder_pack.sv
`default_nettype none
// ============================================================================
// Module      : instr_pack
// Description : Combinational RV32I field packer. Produces the instruction
//               word and flags bundles whose opcode, funct3 or immediate
//               cannot be encoded.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_pack
  import rv::*;
(
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic        alt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] instr_o,
  output logic        illegal_o
);

  // Format selection by opcode; unused fields stay zero
  always_comb begin
    instr_o   = '0;
    illegal_o = 1'b0;
    case (opcode_i)
      RV32_OP_ARITH: begin
        instr_o = {7'b0, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
        instr_o[FUNCT7_ALT_BIT] = alt_i;
      end
      RV32_OP_IMM: begin
        if (funct3_i == RV32_ALU_SLL || funct3_i == RV32_ALU_SR) begin
          // Shift amount lives in the rs2 slot; alt only meaningful for SRAI
          instr_o = {7'b0, imm_i[4:0], rs1_i, funct3_i, rd_i, opcode_i};
          instr_o[FUNCT7_ALT_BIT] = alt_i && (funct3_i == RV32_ALU_SR);
          illegal_o = |imm_i[31:5];
        end else begin
          instr_o   = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
          illegal_o = !fits_signed(imm_i, IMM_I_W);
        end
      end
      RV32_OP_LOAD: begin
        instr_o   = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        illegal_o = !fits_signed(imm_i, IMM_I_W) ||
                    !(funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      end
      RV32_OP_JALR: begin
        instr_o   = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        illegal_o = !fits_signed(imm_i, IMM_I_W) || (funct3_i != 3'b000);
      end
      RV32_OP_STORE: begin
        instr_o   = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        illegal_o = !fits_signed(imm_i, IMM_I_W) || (funct3_i > 3'b010);
      end
      RV32_OP_BRANCH: begin
        instr_o   = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                     imm_i[4:1], imm_i[11], opcode_i};
        illegal_o = !fits_signed(imm_i, IMM_B_W) || imm_i[0] ||
                    (funct3_i inside {3'b010, 3'b011});
      end
      RV32_OP_LUI, RV32_OP_AUIPC: begin
        instr_o   = {imm_i[31:12], rd_i, opcode_i};
        illegal_o = |imm_i[11:0];
      end
      RV32_OP_JAL: begin
        instr_o   = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        illegal_o = !fits_signed(imm_i, IMM_J_W) || imm_i[0];
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder
// Description : Streams packed RV32I words with word-aligned write addresses
//               to an instruction-memory write port; drops and counts bundles
//               that cannot be encoded.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder
  import rv::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic              in_alt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_base,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  word_count,
  output logic [CNT_W-1:0]  err_count
);

  logic [31:0]       pack_instr;
  logic              pack_illegal;

  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_instr_q, out_instr_d;
  logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic              err_q,       err_d;
  logic [CNT_W-1:0]  word_cnt_q,  word_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q,   err_cnt_d;

  logic              accept, xfer, emit, drop;
  logic [ADDR_W-1:0] addr_cur;

  instr_pack u_pack (
    .opcode_i  (in_opcode),
    .funct3_i  (in_funct3),
    .alt_i     (in_alt),
    .rd_i      (in_rd),
    .rs1_i     (in_rs1),
    .rs2_i     (in_rs2),
    .imm_i     (in_imm),
    .instr_o   (pack_instr),
    .illegal_o (pack_illegal)
  );

  // Skid-free pipeline stage: accept whenever the output slot empties this cycle
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid_q && out_ready;
  assign emit     = accept && !pack_illegal;
  assign drop     = accept && pack_illegal;
  // A load in the same cycle as an accept addresses that very word
  assign addr_cur = addr_load ? (addr_base & ~ADDR_W'(3)) : addr_q;

  // Next-state for output register, address counter and statistics
  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_addr_d  = out_addr_q;
    addr_d      = addr_cur;
    err_d       = err_q;
    word_cnt_d  = word_cnt_q;
    err_cnt_d   = err_cnt_q;

    if (emit) begin
      out_valid_d = 1'b1;
      out_instr_d = pack_instr;
      out_addr_d  = addr_cur;
      addr_d      = addr_cur + ADDR_W'(4);
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end

    if (xfer && (word_cnt_q != '1)) begin
      word_cnt_d = word_cnt_q + CNT_W'(1);
    end

    // A coincident clear and drop leaves exactly the new error recorded
    if (drop) begin
      err_d     = 1'b1;
      err_cnt_d = err_clr ? CNT_W'(1)
                : ((err_cnt_q != '1) ? err_cnt_q + CNT_W'(1) : err_cnt_q);
    end else if (err_clr) begin
      err_d     = 1'b0;
      err_cnt_d = '0;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_addr_q  <= '0;
      addr_q      <= '0;
      err_q       <= 1'b0;
      word_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_addr_q  <= out_addr_d;
      addr_q      <= addr_d;
      err_q       <= err_d;
      word_cnt_q  <= word_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_instr  = out_instr_q;
  assign out_addr   = out_addr_q;
  assign err        = err_q;
  assign word_count = word_cnt_q;
  assign err_count  = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder
// Description : Directed and randomized self-checking bench for instr_encoder
//               with an arithmetic reference encoder and transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  in_opcode = '0;
  logic [2:0]  in_funct3 = '0;
  logic        in_alt = 1'b0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        addr_load = 1'b0;
  logic [31:0] addr_base = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err;
  logic        err_clr = 1'b0;
  logic [15:0] word_count;
  logic [15:0] err_count;

  int n_assert = 0;
  int n_fail   = 0;

  instr_encoder #(.ADDR_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_alt(in_alt),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .addr_load(addr_load), .addr_base(addr_base),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .err(err), .err_clr(err_clr),
    .word_count(word_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic alt,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm);
    in_valid  = 1'b1;
    in_opcode = op;
    in_funct3 = f3;
    in_alt    = alt;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_imm    = imm;
  endtask

  // Reference encoder: instruction fields placed by shift/mask arithmetic,
  // legality from numeric ranges of the immediate.
  function automatic void ref_encode(input logic [6:0] op, input logic [2:0] f3,
                                     input logic alt, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [31:0] imm,
                                     output logic [31:0] w, output logic ok);
    int s;
    logic [31:0] o, d, f, a, b;
    s = int'($signed(imm));
    o = 32'(op);
    d = 32'(rd) << 7;
    f = 32'(f3) << 12;
    a = 32'(rs1) << 15;
    b = 32'(rs2) << 20;
    w  = 32'd0;
    ok = 1'b0;
    case (op)
      7'h33: begin ok = 1'b1; w = (32'(alt) << 30) | b | a | f | d | o; end
      7'h13: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          ok = (imm < 32);
          w  = ((f3 == 3'd5 && alt) ? 32'h4000_0000 : 32'd0) |
               ((imm & 32'd31) << 20) | a | f | d | o;
        end else begin
          ok = (s >= -2048 && s <= 2047);
          w  = ((imm & 32'hFFF) << 20) | a | f | d | o;
        end
      end
      7'h03: begin
        ok = (s >= -2048 && s <= 2047) && (f3 != 3'd3 && f3 < 3'd6);
        w  = ((imm & 32'hFFF) << 20) | a | f | d | o;
      end
      7'h67: begin
        ok = (s >= -2048 && s <= 2047) && (f3 == 3'd0);
        w  = ((imm & 32'hFFF) << 20) | a | f | d | o;
      end
      7'h23: begin
        ok = (s >= -2048 && s <= 2047) && (f3 <= 3'd2);
        w  = (((imm >> 5) & 32'd127) << 25) | b | a | f | ((imm & 32'd31) << 7) | o;
      end
      7'h63: begin
        ok = (s >= -4096 && s <= 4095) && (imm[0] == 1'b0) && (f3 != 3'd2 && f3 != 3'd3);
        w  = (((imm >> 12) & 32'd1) << 31) | (((imm >> 5) & 32'd63) << 25) | b | a | f |
             (((imm >> 1) & 32'd15) << 8) | (((imm >> 11) & 32'd1) << 7) | o;
      end
      7'h37, 7'h17: begin
        ok = ((imm & 32'hFFF) == 32'd0);
        w  = (imm & 32'hFFFF_F000) | d | o;
      end
      7'h6F: begin
        ok = (s >= -(1 << 20) && s <= (1 << 20) - 1) && (imm[0] == 1'b0);
        w  = (((imm >> 20) & 32'd1) << 31) | (((imm >> 1) & 32'd1023) << 21) |
             (((imm >> 11) & 32'd1) << 20) | (((imm >> 12) & 32'd255) << 12) | d | o;
      end
      default: ok = 1'b0;
    endcase
  endfunction

  logic [6:0]  ops [9] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

  // Transaction-level model state for the random phase
  logic        m_valid;
  logic [31:0] m_instr, m_addr, m_ctr;
  logic [15:0] m_wc, m_ec;
  logic        m_err;

  initial begin
    logic [31:0] rw, base, rimm;
    logic        rok, acc, xf;

    // ---------------- reset values ----------------
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_addr",  out_addr, 0);
    chk("rst_err",       err, 0);
    chk("rst_word_count", word_count, 0);
    chk("rst_err_count",  err_count, 0);
    rst = 1'b0;
    tick();

    // ---------------- back-to-back SUB, BEQ ----------------
    out_ready = 1'b1;
    drive(7'h33, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0);
    #1 chk("b2b_ready0", in_ready, 1);
    tick();
    chk("sub_instr", out_instr, 32'h402081B3);
    chk("sub_addr",  out_addr, 32'h0);
    chk("sub_valid", out_valid, 1);
    drive(7'h63, 3'd0, 1'b0, 5'd9, 5'd1, 5'd2, 32'hFFFF_FFFC);
    #1 chk("b2b_ready1", in_ready, 1);
    tick();
    chk("beq_instr", out_instr, 32'hFE208EE3);
    chk("beq_addr",  out_addr, 32'h4);
    in_valid = 1'b0;
    tick();
    chk("b2b_drain_valid", out_valid, 0);
    chk("b2b_word_count", word_count, 2);

    // ---------------- ADDI after address load ----------------
    addr_load = 1'b1; addr_base = 32'h100;
    drive(7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd7, 32'hFFFF_FFFF);
    tick();
    addr_load = 1'b0; in_valid = 1'b0;
    chk("addi_instr", out_instr, 32'hFFF00093);
    chk("addi_addr",  out_addr, 32'h100);
    tick();

    // ---------------- stall holding JAL ----------------
    out_ready = 1'b0;
    drive(7'h6F, 3'd0, 1'b0, 5'd1, 5'd3, 5'd4, 32'd2048);
    tick();
    in_valid = 1'b1; in_imm = 32'd16;   // offered but must not be accepted
    for (int i = 0; i < 3; i++) begin
      chk("stall_ready", in_ready, 0);
      chk("stall_instr", out_instr, 32'h001000EF);
      chk("stall_addr",  out_addr, 32'h104);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("stall_drain_valid", out_valid, 0);
    chk("stall_word_count", word_count, 4);

    // ---------------- illegal bundles ----------------
    drive(7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048);
    tick();
    chk("ill_addi_valid", out_valid, 0);
    chk("ill_addi_err", err, 1);
    chk("ill_addi_cnt", err_count, 1);
    drive(7'h63, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3);
    tick();
    chk("ill_beq_cnt", err_count, 2);
    in_valid = 1'b0; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_err", err, 0);
    chk("clr_cnt", err_count, 0);

    // ---------------- boundaries ----------------
    drive(7'h37, 3'd0, 1'b0, 5'd5, 5'd9, 5'd9, 32'h1234_5000);
    tick();
    chk("lui_instr", out_instr, 32'h123452B7);
    chk("lui_addr",  out_addr, 32'h108);
    drive(7'h13, 3'd5, 1'b1, 5'd1, 5'd1, 5'd0, 32'd31);
    tick();
    chk("srai_instr", out_instr, 32'h41F0D093);
    chk("srai_addr",  out_addr, 32'h10C);
    drive(7'h13, 3'd1, 1'b0, 5'd1, 5'd1, 5'd0, 32'd32);
    tick();
    chk("slli32_valid", out_valid, 0);
    chk("slli32_err_cnt", err_count, 1);
    chk("slli32_word_count", word_count, 6);
    drive(7'h7F, 3'd0, 1'b0, 5'd1, 5'd1, 5'd0, 32'd0);
    tick();
    chk("bad_opcode_cnt", err_count, 2);
    err_clr = 1'b1;
    drive(7'h67, 3'd1, 1'b0, 5'd1, 5'd1, 5'd0, 32'd0);
    tick();
    err_clr = 1'b0;
    chk("clr_vs_err_err", err, 1);
    chk("clr_vs_err_cnt", err_count, 1);

    // ---------------- counter wrap ----------------
    addr_load = 1'b1; addr_base = 32'hFFFF_FFFF;
    drive(7'h13, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd5);
    tick();
    addr_load = 1'b0;
    chk("wrap0_instr", out_instr, 32'h00500113);
    chk("wrap0_addr",  out_addr, 32'hFFFF_FFFC);
    drive(7'h13, 3'd0, 1'b0, 5'd2, 5'd2, 5'd0, 32'd1);
    tick();
    chk("wrap1_instr", out_instr, 32'h00110113);
    chk("wrap1_addr",  out_addr, 32'h0);

    // ---------------- reset mid-stream ----------------
    out_ready = 1'b0;
    drive(7'h13, 3'd0, 1'b0, 5'd3, 5'd0, 5'd0, 32'd9);
    tick();
    in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_word_count", word_count, 0);
    chk("midrst_err_count", err_count, 0);
    chk("midrst_addr", out_addr, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_valid", out_valid, 0);

    // ---------------- randomized against the model ----------------
    m_valid = 1'b0; m_instr = '0; m_addr = '0; m_ctr = '0;
    m_wc = '0; m_ec = '0; m_err = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      case ($urandom_range(0, 4))
        0: rimm = 32'($urandom_range(0, 8191)) - 32'd4096;
        1: rimm = $urandom;
        2: rimm = $urandom & 32'hFFFF_F000;
        3: rimm = 32'($urandom_range(0, 40));
        default: rimm = 32'($urandom_range(0, 32'h3F_FFFF)) - 32'h20_0000;
      endcase
      drive(($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)],
            3'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), rimm);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      addr_load = ($urandom_range(0, 15) == 0);
      addr_base = $urandom;
      err_clr   = ($urandom_range(0, 15) == 0);
      #1 chk("rnd_in_ready", in_ready, !m_valid || out_ready);

      ref_encode(in_opcode, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm, rw, rok);
      acc  = in_valid && (!m_valid || out_ready);
      xf   = m_valid && out_ready;
      base = addr_load ? {addr_base[31:2], 2'b00} : m_ctr;
      if (xf && m_wc != 16'hFFFF) m_wc = m_wc + 16'd1;
      if (acc && rok) begin
        m_valid = 1'b1; m_instr = rw; m_addr = base; m_ctr = base + 32'd4;
      end else begin
        if (xf) m_valid = 1'b0;
        m_ctr = base;
      end
      if (acc && !rok) begin
        m_err = 1'b1;
        m_ec  = err_clr ? 16'd1 : ((m_ec != 16'hFFFF) ? m_ec + 16'd1 : m_ec);
      end else if (err_clr) begin
        m_err = 1'b0; m_ec = 16'd0;
      end

      tick();
      chk("rnd_out_valid", out_valid, m_valid);
      if (m_valid) begin
        chk("rnd_out_instr", out_instr, m_instr);
        chk("rnd_out_addr",  out_addr, m_addr);
      end
      chk("rnd_word_count", word_count, m_wc);
      chk("rnd_err", err, m_err);
      chk("rnd_err_count", err_count, m_ec);
    end

    in_valid = 1'b0; addr_load = 1'b0; err_clr = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the RV32I instruction decoder: packs a field bundle (opcode, funct3, rd, rs1, rs2, imm, alt bit) into a 32-bit RV32I instruction word.
- Streams encoded words, each tagged with a word-aligned write address, to the instruction-memory write port.
- Used by the program loader and by self-test benches that generate programs on-chip.
- Validates immediate range and opcode legality, and drops words that cannot be encoded.

Parameters:
- ADDR_W, 32, width of the write-address counter (bits [1:0] always 0).
- CNT_W, 16, width of the emitted-word and error counters.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle
- in_opcode  in  7  rv::RV32_INSTRUCTION_OPCODE
- in_funct3  in  3  rv::RV32_ALU_OPCODE
- in_alt  in  1  instruction bit 30 for ARITHMETIC (SUB/SRA) and IMM shifts (SRAI)
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_imm  in  32  full-value immediate, sign-extended, byte offset for B/J, unshifted-by-caller value for U (low 12 bits must be zero)
- addr_load  in  1  load address counter from addr_base
- addr_base  in  ADDR_W  new base address
- out_valid  out  1  encoded word valid
- out_ready  in  1  downstream accepts word
- out_instr  out  32  encoded instruction
- out_addr  out  ADDR_W  write address for out_instr
- err  out  1  sticky: at least one bundle dropped
- err_clr  in  1  clears err and err_count
- word_count  out  CNT_W  emitted words, saturating
- err_count  out  CNT_W  dropped bundles, saturating

Behaviour:
- Reset values (async on rst high): out_valid=0, out_instr=0, out_addr=0, err=0, word_count=0, err_count=0, address counter=0.
- Handshakes:
  - Input accept = in_valid && in_ready.
  - in_ready = !out_valid || out_ready, combinational, so full throughput is 1 word/cycle.
  - Output transfer = out_valid && out_ready.
  - While out_valid && !out_ready: out_instr and out_addr are held stable and in_ready=0.
- Latency: an accepted legal bundle appears on out_instr/out_valid the next cycle.
  - out_addr equals the counter value at the time the word is registered.
  - The counter advances by 4 on each registered (legal) word.
- Encoding, base: rd=[11:7], funct3=[14:12], rs1=[19:15], rs2=[24:20], opcode=[6:0].
- Encoding per opcode:
  - ARITHMETIC: [31:25] = {1'b0, in_alt, 5'b0}.
  - IMM, LOAD, JALR: [31:20] = imm[11:0].
  - IMM with funct3 001 or 101 (shifts):
    - [24:20] = imm[4:0]; [30] = in_alt (forced 0 for 001); other bits of [31:25] = 0.
    - Legal only if imm[31:5] == 0.
  - STORE: [31:25] = imm[11:5], [11:7] = imm[4:0].
  - BRANCH: [31] = imm[12], [30:25] = imm[10:5], [11:8] = imm[4:1], [7] = imm[11].
  - LUI, AUIPC: [31:12] = imm[31:12].
  - JAL: [31] = imm[20], [30:21] = imm[10:1], [20] = imm[11], [19:12] = imm[19:12].
- Fields unused by an instruction type are driven 0; the bench checks this, it is never x.
- Legality: a bundle is illegal if any of the following holds:
  - I/S immediate: imm[31:11] is not all equal.
  - B immediate: imm[31:12] not all equal, or imm[0] != 0.
  - J immediate: imm[31:20] not all equal, or imm[0] != 0.
  - U immediate: imm[11:0] != 0.
  - Opcode is not one of the nine RV32I base opcodes.
  - LOAD funct3 not in {000, 001, 010, 100, 101}.
  - STORE funct3 not in {000, 001, 010}.
  - BRANCH funct3 is 010 or 011.
  - JALR funct3 != 000.
- Illegal bundle handling:
  - Accepted (consumes the handshake) but not emitted; out_valid is not set.
  - Address counter does not advance.
  - err is set; err_count increments, saturating at all-ones.
  - If out_valid was already set it stays set; only the new word is dropped.
- Counter load: addr_load loads addr_base with bits [1:0] forced 0.
  - If addr_load coincides with a legal accept, the loaded base is used for that word and the counter becomes base+4.
  - A held output word keeps its original out_addr.
- Counter wrap-around: wraps modulo 2^ADDR_W, no flag.
- word_count: increments on each output transfer, saturating.
- err_clr vs error: if err_clr coincides with an illegal accept, the error wins: err=1, err_count=1.
- rst mid-stream: a pending word is lost and all state returns to reset values; nothing is emitted on the cycle after reset release.

Decomposition:
- Package rv: opcode enum (existing), plus new constants:
  - FUNCT7_ALT_BIT = 30.
  - Immediate-width constants IMM_I_W=12, IMM_B_W=13, IMM_J_W=21.
  - Function fits_signed(value, width) for shared range checks.
- One combinational sub-module, instr_pack: fields → {instr, illegal}.
- Top level holds the output register, handshake logic, address counter and statistic counters.

Test Plan:
- ADDI x1,x0,-1 (IMM, f3=000, imm=0xFFFFFFFF) after addr_load base 0x100 → out_instr=0xFFF00093, out_addr=0x100 one cycle after accept.
- Back-to-back SUB x3,x1,x2 then BEQ x1,x2,-4 with out_ready=1 → 0x402081B3 @0x0, 0xFE208EE3 @0x4; in_ready stays 1.
- Stall: out_ready=0 for 3 cycles holding JAL x1,+2048 → out_instr=0x001000EF stable, in_ready=0 throughout, one transfer only, word_count=1.
- Illegal inputs:
  - ADDI imm=2048 → dropped, err=1, err_count=1, counter unchanged.
  - BEQ imm=3 → dropped, err_count=2.
  - err_clr → err=0, err_count=0.
- Boundaries:
  - LUI x5,0x12345000 → 0x123452B7.
  - SRAI x1,x1,31 (alt=1) → 0x41F0D093.
  - SLLI imm=32 → dropped.
- Counter wrap and reset:
  - addr_base=0xFFFFFFFC, two words → out_addr 0xFFFFFFFC then 0x0.
  - rst asserted while out_valid=1 → out_valid=0 immediately, counters 0.
